exe_unit_pipe: RTL
==================

# exe_unit_pipe

Pipelined, parametrised execution unit with valid/ready handshaking on both sides. It computes ADD, COMP, CONV and SET on two WIDTH-bit operands. Each result carries carry, status flags and an error flag, and a saturating error counter tracks failed operations. It replaces the single-register execution unit in the datapath and sits between the operand issue logic and the writeback stage. Backpressure from writeback stalls the pipe without losing data.

## Interface
Parameters:
- WIDTH, 32, operand/result width; ≥4, power of two.
- ERR_CNT_W, 8, error counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rsn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  operand beat offered.
- o_ready  out  1  unit accepts a beat this cycle.
- i_oper  in  `OPER_BITS+1  operation code (alu_defines.vh codes).
- i_argA, i_argB  in  WIDTH  operands.
- o_valid  out  1  result beat offered.
- i_ready  in  1  writeback accepts the result.
- o_result  out  WIDTH  result.
- o_carry  out  1  adder carry-out (0 for non-ADD).
- o_status  out  4  {error, carry, negative, zero} of o_result.
- o_error  out  1  operation failed.
- o_err_cnt  out  ERR_CNT_W  count of accepted failing ops, saturating.

## Operation
- Opcodes:
  - ALU_ADD: result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - ALU_COMP: result = {0…, A==B, A>B}, unsigned compare.
  - ALU_CONV: treat A as sign-magnitude and output two's complement. A = {1, 0…} (negative zero) → result 0, error 1.
  - ALU_SET: result = A with bit B[$clog2(WIDTH)-1:0] set to 1. B ≥ WIDTH → result 0, error 1.
  - Any other code: result 0, error 1.
- Status flags:
  - zero = (o_result==0).
  - negative = o_result[WIDTH-1].
  - carry = o_carry.
  - error = o_error.
- Pipeline stages:
  - S1 registers the opcode and operands (v1).
  - S2 registers the computed result, carry, status and error (v2). Computation is combinational between S1 and S2.
- Stage movement:
  - S2 loads when v1 && (!v2 || i_ready).
  - S1 loads when i_valid && o_ready.
  - o_ready = !v1 || !v2 || i_ready.
- o_valid = v2. S2 outputs stay stable while o_valid && !i_ready.
- o_err_cnt increments when a beat carrying error=1 loads into S2. It holds at all-ones once saturated.

## Timing
- Reset (i_rsn low, asynchronous):
  - v1=v2=0, so o_valid=0 and o_ready=1.
  - o_result=0, o_carry=0, o_status=0, o_error=0, o_err_cnt=0.
  - In-flight beats are discarded.
- Latency: a beat accepted at edge N is presented with o_valid=1 after edge N+1.
- Throughput: 1 beat/cycle while i_ready=1.
- Stalls: with i_ready held low, at most 2 beats are buffered and o_ready falls after the second accept.
- Simultaneous events: accept and drain in the same cycle are legal and keep full throughput. Order is strictly preserved.
- Reset release: the first accept is possible on the first edge after i_rsn rises.

## Configuration
- Macro EXE_UNIT_STICKY_ERR_EN.
  - Defined: adds input i_err_clr (1 bit) and output o_err_sticky (1 bit).
  - o_err_sticky is set when an error beat loads into S2 and cleared by i_err_clr on the next edge. If set and clear coincide, set wins.
  - Reset value of o_err_sticky is 0.
- Not defined: neither port exists and behaviour is otherwise identical.

## Structure
- Package exe_pkg holds:
  - the opcode enum mirroring the alu_defines.vh codes;
  - the status bit index constants (ST_ZERO=0, ST_NEG=1, ST_CARRY=2, ST_ERR=3);
  - a packed struct for the S2 payload (result, carry, status, error).
- Sub-module exe_core: a purely combinational opcode decode/compute from S1 to the S2 payload. Handshake and counters stay in exe_unit_pipe.

## Test plan
Unless stated otherwise, WIDTH=8, i_ready=1, expected values are checked on the o_valid beat, and each stream is compared against a reference model.

- ADD A=F0, B=20 → result 10, carry 1, status 0100, error 0, 2 cycles after accept.
- CONV A=80 → result 00, error 1, status 1001, o_err_cnt 1. CONV A=85 → result FB, status 0010.
- SET A=00, B=09 → result 00, error 1. SET A=00, B=03 → result 08.
- Backpressure: hold i_ready low for 4 cycles while streaming 6 ADD beats.
  - o_ready drops after 2 accepts.
  - After release all 6 results appear in order, with no duplicates and no loss.
- Reset mid-stream: assert i_rsn with 2 beats in flight → o_valid=0 and o_err_cnt=0 immediately. No stale beat appears after release.
- Saturation: issue 300 illegal opcodes → o_err_cnt=FF and it holds. With EXE_UNIT_STICKY_ERR_EN, o_err_sticky=1 until i_err_clr, and set wins on a coincident error.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared opcode, status-index and payload-flag definitions for the pipelined execution unit.
// Opcode values mirror the alu_defines.vh codes; the operation field is OPER_BITS+1 wide.
package exe_pkg;

  localparam int OPER_BITS = 3;
  localparam int OPER_W    = OPER_BITS + 1;

  typedef enum logic [OPER_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_COMP = 4'd1,
    ALU_CONV = 4'd2,
    ALU_SET  = 4'd3
  } exe_op_e;

  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_ERR   = 3;

  // S2 payload fields that do not depend on WIDTH; the result travels beside them.
  typedef struct packed {
    logic       carry;
    logic [3:0] status;
    logic       error;
  } exe_flags_t;

endpackage

// File: rtl/exe_core.sv
// Combinational opcode decode and compute: turns the S1 operands into the S2 payload.
module exe_core
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OPER_W-1:0] oper,
  input  logic [WIDTH-1:0]  arg_a,
  input  logic [WIDTH-1:0]  arg_b,
  output logic [WIDTH-1:0]  result,
  output exe_flags_t        flags
);

  localparam int LOG_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] one;

  assign sum = {1'b0, arg_a} + {1'b0, arg_b};
  assign mag = {1'b0, arg_a[WIDTH-2:0]};
  assign one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    flags  = '0;
    case (oper)
      ALU_ADD: begin
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
      end
      ALU_COMP: begin
        result[1] = (arg_a == arg_b);
        result[0] = (arg_a > arg_b);
      end
      ALU_CONV: begin
        // Sign-magnitude in, two's complement out; negative zero has no encoding to map to.
        if (!arg_a[WIDTH-1])  result      = arg_a;
        else if (mag == '0)   flags.error = 1'b1;
        else                  result      = -mag;
      end
      ALU_SET: begin
        if (|arg_b[WIDTH-1:LOG_W]) flags.error = 1'b1;
        else                       result      = arg_a | (one << arg_b[LOG_W-1:0]);
      end
      default: flags.error = 1'b1;
    endcase
    flags.status[ST_ZERO]  = (result == '0);
    flags.status[ST_NEG]   = result[WIDTH-1];
    flags.status[ST_CARRY] = flags.carry;
    flags.status[ST_ERR]   = flags.error;
  end

endmodule

// File: rtl/exe_unit_pipe.sv
// Two-stage execution unit with valid/ready on both sides and a saturating error counter.
// Optional macro EXE_UNIT_STICKY_ERR_EN adds i_err_clr / o_err_sticky.
module exe_unit_pipe
  import exe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rsn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OPER_W-1:0]    i_oper,
  input  logic [WIDTH-1:0]     i_argA,
  input  logic [WIDTH-1:0]     i_argB,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_carry,
  output logic [3:0]           o_status,
  output logic                 o_error,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`ifdef EXE_UNIT_STICKY_ERR_EN
  ,
  input  logic                 i_err_clr,
  output logic                 o_err_sticky
`endif
);

  logic                 v1, v2;
  logic                 ld1, ld2;
  logic [OPER_W-1:0]    op1;
  logic [WIDTH-1:0]     a1, b1;
  logic [WIDTH-1:0]     core_result, result2;
  exe_flags_t           core_flags, flags2;
  logic [ERR_CNT_W-1:0] err_cnt;

  // Handshake: a beat moves across a boundary on an edge where the sender's valid and the
  // receiver's ready are both high. S2 moves when it is empty or writeback drains it; S1 accepts
  // whenever either stage has room or S2 drains, so two beats fill the pipe under backpressure.
  assign ld2     = v1 && (!v2 || i_ready);
  assign o_ready = !v1 || !v2 || i_ready;
  assign ld1     = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      v1  <= 1'b0;
      op1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else if (ld1) begin
      v1  <= 1'b1;
      op1 <= i_oper;
      a1  <= i_argA;
      b1  <= i_argB;
    end else if (ld2) begin
      v1  <= 1'b0;
    end
  end

  exe_core #(.WIDTH(WIDTH)) u_core (
    .oper   (op1),
    .arg_a  (a1),
    .arg_b  (b1),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      v2      <= 1'b0;
      result2 <= '0;
      flags2  <= '0;
    end else if (ld2) begin
      v2      <= 1'b1;
      result2 <= core_result;
      flags2  <= core_flags;
    end else if (i_ready) begin
      v2      <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn)                                          err_cnt <= '0;
    else if (ld2 && core_flags.error && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
  end

`ifdef EXE_UNIT_STICKY_ERR_EN
  // A new error outranks a clear arriving on the same edge.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn)                        o_err_sticky <= 1'b0;
    else if (ld2 && core_flags.error)  o_err_sticky <= 1'b1;
    else if (i_err_clr)                o_err_sticky <= 1'b0;
  end
`endif

  assign o_valid   = v2;
  assign o_result  = result2;
  assign o_carry   = flags2.carry;
  assign o_status  = flags2.status;
  assign o_error   = flags2.error;
  assign o_err_cnt = err_cnt;

endmodule
